router_dst_reader: RTL and testbench
====================================

Name: router_dst_reader

Overview:
- Destination-side consumer for one 1x3 router output port. It is the read end of the path whose write side is router_sync.
- Watches vld_out (FIFO not empty) and drives read_enb to drain the output FIFO one packet at a time.
- Parses header, payload and parity bytes, checks parity, and presents bytes downstream with sink_ready backpressure.
- Keeps the FIFO drained so router_sync's 30-cycle unread timeout does not fire under normal traffic.

Parameters:
- DATA_W, 8, FIFO byte width. Header layout is fixed at [7:2] length, [1:0] address.
- PORT_ID, 2'd0, this port's address. Used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- vld_out  in  1  FIFO non-empty, from router_sync.
- soft_reset  in  1  synchronous abort, from router_sync soft_reset_n.
- dout  in  8  FIFO read data; valid one cycle after read_enb is sampled high.
- sink_ready  in  1  downstream can accept a byte this cycle.
- read_enb  out  1  FIFO read strobe, to router_sync read_enb_n and the FIFO.
- byte_data  out  8  captured byte.
- byte_valid  out  1  byte_data valid; one-cycle pulse per byte.
- sof  out  1  qualifies the header byte.
- eof  out  1  qualifies the parity byte.
- pkt_len  out  6  latched payload length.
- pkt_done  out  1  one-cycle pulse after the parity byte.
- parity_err  out  1  valid with pkt_done; held until the next sof.
- pkt_abort  out  1  one-cycle pulse when soft_reset kills a packet in progress.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE. All outputs 0. Internal counters and parity accumulator 0.
- Read latency: read_enb high in cycle t gives capture of dout at edge t+1. An internal rd_d flag marks capture cycles.
- Read issue rule: read_enb = (state is HDR_RD or BODY_RD) & vld_out & sink_ready & (issued < total). read_enb is never registered high while vld_out=0.
- IDLE: when vld_out=1 and sink_ready=1, go to HDR_RD.
- HDR_RD: assert read_enb for exactly one cycle, then go to HDR_WAIT with read_enb=0.
- HDR_WAIT: capture the header.
  - pkt_len <= dout[7:2]; total = pkt_len+2; issued = 1.
  - parity accumulator <= dout.
  - byte_valid=1, sof=1, parity_err cleared.
  - Go to BODY_RD.
- BODY_RD: issue reads while the issue rule holds. Each capture does byte_valid=1 and increments the captured count.
  - Indices 1..pkt_len are payload bytes; each XORs into the accumulator.
  - Index pkt_len+1 is the parity byte: eof=1, compare with the accumulator, go to DONE.
- DONE: one cycle.
  - pkt_done=1; parity_err=(parity byte != accumulator).
  - Go to IDLE. A back-to-back packet may start HDR_RD on the next cycle.
- pkt_len=0 is legal: header, then parity byte, with zero payload bytes.
- vld_out drops mid-packet (writer slower than reader): read_enb deasserts and the FSM holds its state; resume when vld_out returns. Any in-flight capture still completes.
- sink_ready low: no new read is issued. A capture already in flight is still presented; the downstream must absorb one byte of skid.
- soft_reset=1 in any non-IDLE state, checked before all other transitions:
  - Go to IDLE; read_enb=0 in that same cycle.
  - pkt_abort=1 for one cycle; no pkt_done.
  - Counters and accumulator cleared; an in-flight capture is discarded (byte_valid=0).
- soft_reset in IDLE: no effect; pkt_abort=0.
- Counters are 7 bits (max total = 65). No wrap occurs within a packet.
- resetn asserted mid-packet: immediate return to reset values.

Optional Feature:
- Macro: ROUTER_DST_ADDR_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit), set at header capture if dout[1:0] != PORT_ID and held until the next sof.
  - The packet is still drained completely, so the FIFO never stalls.
  - pkt_done still pulses.
  - byte_valid is suppressed for that packet's bytes.
- Undefined: no addr_err port; address bits are ignored; all bytes are forwarded.

Test Plan:
- Reset, then a FIFO holding header 8'h0E (len 3, addr 2'b10), payload 11,22,33 and parity 8'h0E^11^22^33=8'h0E, with sink_ready=1.
  -> read_enb high for 1 cycle, low for 1 cycle, then 4 cycles.
  -> 5 byte_valid pulses, sof on 8'h0E, eof on the last byte.
  -> pkt_done=1 with parity_err=0; pkt_len=3.
- Same packet with parity byte 8'hFF -> pkt_done=1, parity_err=1, held until the next sof.
- Header 8'h00 (len 0) followed by parity 8'h00 -> 2 bytes total; pkt_done=1, parity_err=0.
- len 4 packet, vld_out forced 0 for 5 cycles after payload byte 2, and sink_ready 0 for 3 cycles later.
  -> read_enb=0 throughout both gaps; no byte is lost or duplicated; parity_err=0.
- soft_reset pulsed after payload byte 1 of a len 5 packet.
  -> next cycle: state=IDLE, read_enb=0, pkt_abort=1, no pkt_done.
  -> the following packet is then received correctly.
- With ROUTER_DST_ADDR_CHECK_EN, PORT_ID=0, header 8'h09 (addr 1, len 2).
  -> addr_err=1; 4 reads are still issued; byte_valid stays 0; pkt_done=1.

Source files
------------

// File: rtl/router_dst_reader.sv
// router_dst_reader: drains one router output FIFO a packet at a time, checks parity and forwards bytes.
// Optional ROUTER_DST_ADDR_CHECK_EN adds addr_err and silently drains packets addressed to another port.
module router_dst_reader #(
    parameter int unsigned DATA_W  = 8,
    parameter logic [1:0]  PORT_ID = 2'd0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic              soft_reset,
    input  logic [DATA_W-1:0] dout,
    input  logic              sink_ready,
    output logic              read_enb,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid,
    output logic              sof,
    output logic              eof,
    output logic [5:0]        pkt_len,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              pkt_abort,
`ifdef ROUTER_DST_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, BODY_RD, DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic [6:0]        issued_q, issued_d;
    logic [6:0]        total_q, total_d;
    logic [6:0]        cap_q, cap_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [5:0]        len_q, len_d;
    logic              bv_q, bv_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              abort_q, abort_d;
    logic              drop_q, drop_d;
    logic              can_issue;
    logic              hdr_drop;

`ifdef ROUTER_DST_ADDR_CHECK_EN
    assign hdr_drop = (dout[1:0] != PORT_ID);
    assign addr_err = drop_q;
`else
    // Address bits carry no meaning in this build; every packet is forwarded.
    assign hdr_drop = 1'b0 & (dout[1:0] != PORT_ID);
`endif

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        total_d   = total_q;
        cap_d     = cap_q;
        acc_d     = acc_q;
        len_d     = len_q;
        data_d    = data_q;
        drop_d    = drop_q;
        perr_d    = perr_q;
        bv_d      = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        read_enb  = 1'b0;
        can_issue = vld_out & sink_ready;

        // Abort wins over everything; a capture landing this cycle is dropped.
        if (soft_reset && (state_q != IDLE)) begin
            state_d  = IDLE;
            abort_d  = 1'b1;
            issued_d = '0;
            total_d  = '0;
            cap_d    = '0;
            acc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (can_issue) state_d = HDR_RD;
                end
                HDR_RD: begin
                    if (can_issue) begin
                        read_enb = 1'b1;
                        state_d  = HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (rd_pend_q) begin
                        len_d    = dout[7:2];
                        total_d  = {1'b0, dout[7:2]} + 7'd2;
                        issued_d = 7'd1;
                        cap_d    = 7'd1;
                        acc_d    = dout;
                        data_d   = dout;
                        drop_d   = hdr_drop;
                        bv_d     = ~hdr_drop;
                        sof_d    = ~hdr_drop;
                        perr_d   = 1'b0;
                        state_d  = BODY_RD;
                    end
                end
                BODY_RD: begin
                    read_enb = can_issue && (issued_q < total_q);
                    if (read_enb) issued_d = issued_q + 7'd1;
                    if (rd_pend_q) begin
                        data_d = dout;
                        bv_d   = ~drop_q;
                        if (cap_q == ({1'b0, len_q} + 7'd1)) begin
                            eof_d   = ~drop_q;
                            state_d = DONE;
                        end else begin
                            acc_d = acc_q ^ dout;
                            cap_d = cap_q + 7'd1;
                        end
                    end
                end
                DONE: begin
                    // data_q still holds the parity byte here.
                    done_d  = 1'b1;
                    perr_d  = (data_q != acc_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        rd_pend_d = read_enb;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
            issued_q  <= '0;
            total_q   <= '0;
            cap_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            len_q     <= '0;
            bv_q      <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            abort_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            issued_q  <= issued_d;
            total_q   <= total_d;
            cap_q     <= cap_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            len_q     <= len_d;
            bv_q      <= bv_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            abort_q   <= abort_d;
            drop_q    <= drop_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = bv_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign pkt_len    = len_q;
    assign pkt_done   = done_q;
    assign parity_err = perr_q;
    assign pkt_abort  = abort_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_router_dst_reader.sv
// Bench for router_dst_reader: a queue-based FIFO feeds packets, and a packet-level model predicts
// the forwarded byte stream, packet results and aborts. Builds with or without ROUTER_DST_ADDR_CHECK_EN.
module tb_router_dst_reader;

`ifdef ROUTER_DST_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic       soft_reset;
    logic [7:0] dout;
    logic       sink_ready;
    logic       read_enb;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       sof;
    logic       eof;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       pkt_abort;
    logic       busy;
`ifdef ROUTER_DST_ADDR_CHECK_EN
    logic       addr_err;
`endif

    router_dst_reader #(.DATA_W(8), .PORT_ID(2'd0)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .dout       (dout),
        .sink_ready (sink_ready),
        .read_enb   (read_enb),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .sof        (sof),
        .eof        (eof),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_abort  (pkt_abort),
`ifdef ROUTER_DST_ADDR_CHECK_EN
        .addr_err   (addr_err),
`endif
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] fifo [$];
    logic [7:0] pay [$];
    logic [9:0] exp_bytes [$];   // {sof, eof, data}
    logic [6:0] exp_pkts [$];    // {parity_err, len}
    bit         trace [$];

    bit vgate = 1'b0;
    bit sgate = 1'b0;
    int rd_count = 0;
    int bytes_seen = 0;
    int exp_seen = 0;
    int pkts_seen = 0;
    int exp_pkts_total = 0;
    int aborts_seen = 0;
    int exp_aborts = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic monitor();
        logic [9:0] e;
        logic [6:0] p;
        if (!resetn) return;
        if (byte_valid) begin
            bytes_seen++;
            if (exp_bytes.size() == 0) check("extra_byte", {sof, eof, byte_data}, 10'h3ff);
            else begin
                e = exp_bytes.pop_front();
                check("byte", {sof, eof, byte_data}, e);
            end
            if (sof) check("perr_clear_at_sof", parity_err, 1'b0);
        end else begin
            check("qual_without_valid", {sof, eof}, 2'b00);
        end
        if (pkt_done) begin
            pkts_seen++;
            if (exp_pkts.size() == 0) check("extra_pkt_done", pkt_done, 1'b0);
            else begin
                p = exp_pkts.pop_front();
                check("pkt_len", pkt_len, p[5:0]);
                check("parity_err", parity_err, p[6]);
            end
        end
        if (pkt_abort) aborts_seen++;
    endtask

    // One clock cycle, entered and left at negedge+1: apply inputs, sample the read strobe
    // before the edge, deliver FIFO data after it, then observe outputs at the next negedge.
    task automatic tick();
        bit re;
        vld_out    = (fifo.size() != 0) && !vgate;
        sink_ready = !sgate;
        #2;
        re = read_enb;
        trace.push_back(re);
        if (re) begin
            rd_count++;
            check("read_while_empty", vld_out, 1'b1);
        end
        @(posedge clock);
        #1;
        if (re) begin
            if (fifo.size() != 0) dout = fifo.pop_front();
            else check("fifo_underflow", 1'b1, 1'b0);
        end
        @(negedge clock);
        monitor();
        #1;
    endtask

    // Parity is the XOR of header and payload unless a specific parity byte is forced.
    task automatic send_pkt(input logic [7:0] hdr, input bit force_par, input logic [7:0] par_val);
        logic [7:0] par;
        bit         drop;
        bit         perr;
        par = hdr;
        foreach (pay[i]) par ^= pay[i];
        drop = ADDR_CHK && (hdr[1:0] != 2'd0);
        perr = force_par && (par_val != par);
        if (force_par) par = par_val;
        fifo.push_back(hdr);
        if (!drop) exp_bytes.push_back({2'b10, hdr});
        foreach (pay[i]) begin
            fifo.push_back(pay[i]);
            if (!drop) exp_bytes.push_back({2'b00, pay[i]});
        end
        fifo.push_back(par);
        if (!drop) begin
            exp_bytes.push_back({2'b01, par});
            exp_seen += pay.size() + 2;
        end
        exp_pkts.push_back({perr, hdr[7:2]});
        exp_pkts_total++;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while ((fifo.size() != 0 || exp_bytes.size() != 0 || exp_pkts.size() != 0 || busy) && n < budget) begin
            if (rnd) begin
                vgate = ($urandom_range(0, 3) == 0);
                sgate = ($urandom_range(0, 4) == 0);
            end
            tick();
            n++;
        end
        vgate = 1'b0;
        sgate = 1'b0;
        check("drain_timeout", n < budget, 1'b1);
        tick();
    endtask

    task automatic wait_bytes(input int target, input string tag);
        int n = 0;
        while (bytes_seen < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, n < 200, 1'b1);
    endtask

    task automatic flush_model();
        fifo.delete();
        exp_bytes.delete();
        exp_pkts.delete();
        exp_pkts_total = pkts_seen;
        exp_seen = bytes_seen;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_chk=%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int         rd0;
        int         b0;
        int         t0;
        int         first;
        logic [6:0] pat;
        logic [7:0] hdr;
        int         len;

        resetn     = 1'b0;
        vld_out    = 1'b0;
        soft_reset = 1'b0;
        sink_ready = 1'b0;
        dout       = 8'h00;
        @(negedge clock);
        #1;
        repeat (2) tick();
        check("reset_outputs",
              {read_enb, byte_valid, sof, eof, pkt_len, pkt_done, parity_err, pkt_abort, busy}, 14'h0);
        resetn = 1'b1;
        tick();

        // Basic packet: len 3, addr 2, correct parity 8'h0E.
        rd0 = rd_count; b0 = bytes_seen; t0 = trace.size();
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0E, 1'b1, 8'h0E);
        wait_idle(300, 1'b0);
        first = -1;
        for (int i = t0; i < trace.size(); i++) if (first < 0 && trace[i]) first = i;
        pat = '0;
        if (first >= 0)
            for (int k = 0; k < 7; k++)
                if (first + k < trace.size()) pat[6-k] = trace[first+k];
        check("read_pattern", pat, 7'b1011110);
        check("reads_len3", rd_count - rd0, 5);
        check("bytes_len3", bytes_seen - b0, exp_seen - b0);
        check("pkt_len_latched", pkt_len, 6'd3);

        // Corrupt parity byte; error must persist until the next header.
        rd0 = rd_count;
        send_pkt(8'h0E, 1'b1, 8'hFF);
        wait_idle(300, 1'b0);
        repeat (3) tick();
        check("perr_held", parity_err, 1'b1);

        // Zero-length packet.
        rd0 = rd_count; b0 = bytes_seen;
        pay.delete();
        send_pkt(8'h00, 1'b0, 8'h00);
        wait_idle(300, 1'b0);
        check("reads_len0", rd_count - rd0, 2);
        check("bytes_len0", bytes_seen - b0, 2);
        check("perr_len0", parity_err, 1'b0);

        // Maximum length: 65 bytes total.
        rd0 = rd_count;
        pay.delete();
        for (int i = 0; i < 63; i++) pay.push_back(8'($urandom));
        send_pkt(8'hFC, 1'b0, 8'h00);
        wait_idle(1000, 1'b0);
        check("reads_len63", rd_count - rd0, 65);

        // Writer stall then sink backpressure inside a len 4 packet.
        rd0 = rd_count; b0 = bytes_seen;
        pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_pkt(8'h10, 1'b0, 8'h00);
        wait_bytes(b0 + 3, "gap_reach_payload2");
        t0 = rd_count;
        vgate = 1'b1;
        repeat (5) tick();
        vgate = 1'b0;
        check("reads_during_vld_gap", rd_count - t0, 0);
        t0 = rd_count;
        sgate = 1'b1;
        repeat (3) tick();
        sgate = 1'b0;
        check("reads_during_sink_gap", rd_count - t0, 0);
        wait_idle(300, 1'b0);
        check("reads_gapped", rd_count - rd0, 6);
        check("bytes_gapped", bytes_seen - b0, 6);

        // Soft reset after payload byte 1 of a len 5 packet.
        b0 = bytes_seen;
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_pkt(8'h14, 1'b0, 8'h00);
        wait_bytes(b0 + 2, "abort_reach_payload1");
        soft_reset = 1'b1;
        flush_model();
        exp_aborts++;
        tick();
        check("abort_pulse", pkt_abort, 1'b1);
        check("abort_idle", busy, 1'b0);
        check("abort_no_read", read_enb, 1'b0);
        soft_reset = 1'b0;
        tick();
        check("abort_one_cycle", pkt_abort, 1'b0);
        rd0 = rd_count;
        pay = '{8'h5A, 8'hC3};
        send_pkt(8'h08, 1'b0, 8'h00);
        wait_idle(300, 1'b0);
        check("reads_after_abort", rd_count - rd0, 4);

        // Soft reset while idle is ignored.
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("idle_soft_reset_no_abort", pkt_abort, 1'b0);

        // Asynchronous reset in the middle of a packet.
        b0 = bytes_seen;
        pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        send_pkt(8'h18, 1'b0, 8'h00);
        wait_bytes(b0 + 3, "rst_reach_payload2");
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs",
              {read_enb, byte_valid, sof, eof, pkt_len, pkt_done, parity_err, pkt_abort, busy}, 14'h0);
        flush_model();
        tick();
        resetn = 1'b1;
        tick();

`ifdef ROUTER_DST_ADDR_CHECK_EN
        // Misaddressed packet is drained but not forwarded.
        rd0 = rd_count; b0 = bytes_seen;
        pay = '{8'h77, 8'h88};
        send_pkt(8'h09, 1'b0, 8'h00);
        wait_idle(300, 1'b0);
        check("addr_err_set", addr_err, 1'b1);
        check("addr_reads", rd_count - rd0, 4);
        check("addr_no_bytes", bytes_seen - b0, 0);
        pay = '{8'h99};
        send_pkt(8'h04, 1'b0, 8'h00);
        wait_idle(300, 1'b0);
        check("addr_err_cleared", addr_err, 1'b0);
`endif

        // Randomised bursts of back-to-back packets with random stalls.
        for (int p = 0; p < 24; p++) begin
            int burst;
            burst = $urandom_range(1, 3);
            for (int b = 0; b < burst; b++) begin
                len = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 12);
                pay.delete();
                for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
                hdr[7:2] = 6'(len);
                hdr[1:0] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
                send_pkt(hdr, ($urandom_range(0, 3) == 0), 8'($urandom));
            end
            wait_idle(3000, 1'b1);
        end

        check("total_pkt_done", pkts_seen, exp_pkts_total);
        check("total_bytes", bytes_seen, exp_seen);
        check("total_aborts", aborts_seen, exp_aborts);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
